// File: rtl/hex_display_scan.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment displays.
// Optional decimal-point support is enabled by defining HEX_DISPLAY_DP_EN.
module hex_display_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
`ifdef HEX_DISPLAY_DP_EN
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  output logic                    dp,
`endif
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SLOTS = 1 << IDX_W;

  logic [4*NUM_DIGITS-1:0] shadow_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [6:0]              seg_reg, seg_next;
  logic [NUM_DIGITS-1:0]   an_reg, an_next;
  logic [NUM_DIGITS-1:0]   active_an;
  logic [SLOTS-1:0]        zero_above;
  logic [3:0]              cur_nibble;
  logic                    in_dead;
  logic                    blanked;
  logic                    lit;

  function automatic logic [6:0] encode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= '0;
    end else if (load) begin
      shadow_reg <= value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      idx_reg <= '0;
    end else if (cnt_reg == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_reg <= '0;
      idx_reg <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + IDX_W'(1);
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // zero_above[k]: nibbles k..top are all zero; padding slots are never selected.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    if (gi < NUM_DIGITS) begin : g_real
      assign zero_above[gi] = ~|shadow_reg[4*NUM_DIGITS-1:4*gi];
      assign active_an[gi]  = ~(idx_reg == IDX_W'(gi));
    end else begin : g_pad
      assign zero_above[gi] = 1'b1;
    end
  end

  if (DEAD_CYCLES == 0) begin : g_no_dead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = cnt_reg < CNT_W'(DEAD_CYCLES);
  end

  assign cur_nibble = shadow_reg[{idx_reg, 2'b00} +: 4];
  assign blanked    = blank_lz && (idx_reg != '0) && zero_above[idx_reg];
  assign lit        = !in_dead && !blanked;

  always_comb begin
    seg_next = 7'b1111111;
    an_next  = '1;
    if (lit) begin
      seg_next = encode(cur_nibble);
      an_next  = active_an;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg <= 7'b1111111;
      an_reg  <= '1;
    end else begin
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign seg = seg_reg;
  assign an  = an_reg;

`ifdef HEX_DISPLAY_DP_EN
  logic [NUM_DIGITS-1:0] dp_shadow_reg;
  logic [SLOTS-1:0]      dp_pad;
  logic                  dp_reg, dp_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_shadow_reg <= '0;
    end else if (load) begin
      dp_shadow_reg <= dp_mask;
    end
  end

  assign dp_pad  = SLOTS'(dp_shadow_reg);
  assign dp_next = lit ? ~dp_pad[idx_reg] : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_reg <= 1'b1;
    end else begin
      dp_reg <= dp_next;
    end
  end

  assign dp = dp_reg;
`endif

endmodule

// File: tb/tb_hex_display_scan.sv
// Self-checking bench for hex_display_scan: a 4-digit instance (DIV=8, DEAD=1)
// and a 1-digit instance (DIV=2, DEAD=0) share stimulus and are checked every cycle.
module tb_hex_display_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value = '0;
  logic [6:0]  seg, seg1;
  logic [3:0]  an;
  logic        an1;
`ifdef HEX_DISPLAY_DP_EN
  logic [3:0]  dp_mask = '0;
  logic        dp, dp1;
  logic [3:0]  dpm_m;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_display_scan #(.NUM_DIGITS(4), .REFRESH_DIV(8), .DEAD_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value), .blank_lz(blank_lz),
`ifdef HEX_DISPLAY_DP_EN
    .dp_mask(dp_mask), .dp(dp),
`endif
    .seg(seg), .an(an)
  );

  hex_display_scan #(.NUM_DIGITS(1), .REFRESH_DIV(2), .DEAD_CYCLES(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value[3:0]), .blank_lz(blank_lz),
`ifdef HEX_DISPLAY_DP_EN
    .dp_mask(dp_mask[0:0]), .dp(dp1),
`endif
    .seg(seg1), .an(an1)
  );

  // Segment patterns for hex digits 0..F, active low gfedcba.
  logic [6:0] enc_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  typedef struct {
    logic [6:0] seg;
    logic [7:0] an;
    logic       lit;
    int         idx;
  } out_t;

  // Reference: position p = clock edges since reset release before the state used.
  function automatic out_t model(int nd, int div, int dead, int pos, logic [15:0] sh, logic blz);
    out_t o;
    int cnt, idx, upper;
    cnt   = pos % div;
    idx   = (pos / div) % nd;
    upper = int'(sh) >> (4 * idx);
    o.idx = idx;
    o.lit = (cnt >= dead) && !(blz && idx > 0 && upper == 0);
    o.seg = o.lit ? enc_tab[upper & 15] : 7'h7F;
    o.an  = o.lit ? 8'(((1 << nd) - 1) & ~(1 << idx)) : 8'((1 << nd) - 1);
    return o;
  endfunction

  int          e;
  logic [15:0] sh_m;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    out_t o0, o1;
    logic [3:0] dpv0, dpv1;
    @(posedge clk);
    if (!rst_n) begin
      o0.seg = 7'h7F; o0.an = 8'hF; o0.lit = 1'b0; o0.idx = 0;
      o1.seg = 7'h7F; o1.an = 8'h1; o1.lit = 1'b0; o1.idx = 0;
      dpv0 = '0; dpv1 = '0;
    end else begin
      o0 = model(4, 8, 1, e, sh_m, blank_lz);
      o1 = model(1, 2, 0, e, {12'b0, sh_m[3:0]}, blank_lz);
`ifdef HEX_DISPLAY_DP_EN
      dpv0 = dpm_m;
      dpv1 = {3'b0, dpm_m[0]};
`else
      dpv0 = '0; dpv1 = '0;
`endif
      if (load) begin
        sh_m = value;
`ifdef HEX_DISPLAY_DP_EN
        dpm_m = dp_mask;
`endif
      end
      e++;
    end
    #1;
    chk("seg4", 32'(seg), 32'(o0.seg));
    chk("an4", 32'(an), 32'(o0.an));
    chk("seg1", 32'(seg1), 32'(o1.seg));
    chk("an1", 32'(an1), 32'(o1.an));
`ifdef HEX_DISPLAY_DP_EN
    chk("dp4", 32'(dp), 32'(o0.lit ? ~dpv0[o0.idx] : 1'b1));
    chk("dp1", 32'(dp1), 32'(o1.lit ? ~dpv1[0] : 1'b1));
`else
    if (dpv0 != dpv1) chk("dp_unused", 32'(dpv0), 32'(dpv1));
`endif
  endtask

  // Asserts reset off-edge, checks it acts without a clock, then releases.
  task automatic reset_seq();
    rst_n = 1'b0;
    #1;
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_an", 32'(an), 32'hF);
    chk("async_rst_an1", 32'(an1), 32'h1);
`ifdef HEX_DISPLAY_DP_EN
    chk("async_rst_dp", 32'(dp), 32'h1);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    e = 0;
    sh_m = '0;
`ifdef HEX_DISPLAY_DP_EN
    dpm_m = '0;
`endif
  endtask

  typedef struct {
    logic [15:0] value;
    logic        blz;
    int          digit;
    logic [6:0]  seg;
    logic [3:0]  an;
  } vec_t;

  vec_t vecs [16];
  int   n_vec;

  initial begin
    vecs[0]  = '{16'h12AF, 1'b0, 0, 7'b0001110, 4'b1110};
    vecs[1]  = '{16'h12AF, 1'b0, 1, 7'b0001000, 4'b1101};
    vecs[2]  = '{16'h12AF, 1'b0, 2, 7'b0100100, 4'b1011};
    vecs[3]  = '{16'h12AF, 1'b0, 3, 7'b1111001, 4'b0111};
    vecs[4]  = '{16'h0030, 1'b1, 0, 7'b1000000, 4'b1110};
    vecs[5]  = '{16'h0030, 1'b1, 1, 7'b0110000, 4'b1101};
    vecs[6]  = '{16'h0030, 1'b1, 2, 7'b1111111, 4'b1111};
    vecs[7]  = '{16'h0030, 1'b1, 3, 7'b1111111, 4'b1111};
    vecs[8]  = '{16'h0000, 1'b1, 0, 7'b1000000, 4'b1110};
    vecs[9]  = '{16'h0000, 1'b1, 1, 7'b1111111, 4'b1111};
    vecs[10] = '{16'h0000, 1'b1, 3, 7'b1111111, 4'b1111};
    vecs[11] = '{16'h0105, 1'b1, 1, 7'b1000000, 4'b1101};
    vecs[12] = '{16'h0105, 1'b1, 0, 7'b0010010, 4'b1110};
    vecs[13] = '{16'h0105, 1'b1, 2, 7'b1111001, 4'b1011};
    vecs[14] = '{16'h0000, 1'b0, 3, 7'b1000000, 4'b0111};
    vecs[15] = '{16'h8000, 1'b1, 3, 7'b0000000, 4'b0111};
    n_vec = 16;

    #1;
    reset_seq();

    for (int i = 0; i < n_vec; i++) begin
      reset_seq();
      value = vecs[i].value;
      blank_lz = vecs[i].blz;
      load = 1'b1;
      tick();
      chk("first_dead_an", 32'(an), 32'hF);
      load = 1'b0;
      repeat (vecs[i].digit * 8 + 3) tick();
      chk("vec_seg", 32'(seg), 32'(vecs[i].seg));
      chk("vec_an", 32'(an), 32'(vecs[i].an));
      $display("vector %0d value=%h blank_lz=%b digit=%0d seg=%b an=%b", i, vecs[i].value,
               vecs[i].blz, vecs[i].digit, seg, an);
    end

    // Capture mid-slot: content changes next edge, scan timing does not.
    reset_seq();
    blank_lz = 1'b0;
    value = 16'h1111;
    load = 1'b1;
    tick();
    load = 1'b0;
    repeat (11) tick();
    value = 16'h2222;
    load = 1'b1;
    tick();
    chk("midload_old_seg", 32'(seg), 32'b1111001);
    chk("midload_old_an", 32'(an), 32'b1101);
    load = 1'b0;
    tick();
    chk("midload_new_seg", 32'(seg), 32'b0100100);
    chk("midload_new_an", 32'(an), 32'b1101);
    repeat (2) tick();
    chk("midload_slot_end_an", 32'(an), 32'b1101);
    tick();
    chk("midload_boundary_dead", 32'(an), 32'b1111);
    tick();
    chk("midload_next_digit_an", 32'(an), 32'b1011);
    chk("midload_next_digit_seg", 32'(seg), 32'b0100100);
    $display("mid-slot load 1111->2222 seg=%b an=%b", seg, an);

`ifdef HEX_DISPLAY_DP_EN
    reset_seq();
    dp_mask = 4'b0100;
    value = 16'h1234;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("dp_rule", 32'(dp), (an == 4'b1011) ? 32'h0 : 32'h1);
    end
    $display("dp sequence mask=0100 value=1234 done");
`endif

    // Randomised stimulus against the reference model, with one mid-run reset.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) reset_seq();
      load = ($urandom % 8) == 0;
      if (load) begin
        logic [15:0] v;
        v = '0;
        for (int k = 0; k < 4; k++)
          if ($urandom % 2) v[4*k +: 4] = 4'($urandom % 16);
        value = v;
`ifdef HEX_DISPLAY_DP_EN
        dp_mask = 4'($urandom % 16);
`endif
        $display("random load value=%h blank_lz=%b", value, blank_lz);
      end
      if (($urandom % 32) == 0) blank_lz = ~blank_lz;
      tick();
    end
    load = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
